reg_file_scoreboard: RTL and testbench

Register file with one write port and two combinational read ports. It also carries a per-register scoreboard of in-flight writes and tells the decode stage whether an operand is still pending. It is the read side of the pipeline's register storage: decode reads operands and issues destinations here, and writeback updates values and retires destinations. It provides same-cycle write-to-read bypass, so a writeback and a read of the same register in one cycle need no extra forwarding stage.

---
 rtl/reg_file_scoreboard.sv | 97 +++++++++
 tb/tb_reg_file_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register in-flight writer scoreboard with same-cycle writeback bypass.
module reg_file_scoreboard #(
    parameter int WIDTH = 32,
    parameter int REGS  = 8,
    parameter int CNT_W = 2,
    parameter int AW    = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ok,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [WIDTH-1:0] regs_q [REGS];
    logic [WIDTH-1:0] regs_d [REGS];
    logic [CNT_W-1:0] cnt_q  [REGS];
    logic [CNT_W-1:0] cnt_d  [REGS];
    logic             wb_err_q;
    logic             wb_err_d;

    logic             wb_live;
    logic             hit1;
    logic             hit2;
    logic [REGS-1:0]  inc_v;
    logic [REGS-1:0]  dec_v;

    assign wb_live = wb_en && (wb_addr != '0);
    assign hit1    = wb_live && (wb_addr == rs1_addr);
    assign hit2    = wb_live && (wb_addr == rs2_addr);

    // A pending writeback this cycle retires one writer for the busy view.
    always_comb begin
        rs1_data = hit1 ? wb_data : regs_q[rs1_addr];
        rs2_data = hit2 ? wb_data : regs_q[rs2_addr];
        rs1_busy = hit1 ? (cnt_q[rs1_addr] > CNT_W'(1))
                        : (cnt_q[rs1_addr] != '0);
        rs2_busy = hit2 ? (cnt_q[rs2_addr] > CNT_W'(1))
                        : (cnt_q[rs2_addr] != '0);
    end

    assign issue_ok = issue_en &&
                      ((issue_rd == '0) ||
                       (cnt_q[issue_rd] != MAX) ||
                       (wb_en && (wb_addr == issue_rd)));

    assign wb_err = wb_err_q;

    always_comb begin
        regs_d   = regs_q;
        cnt_d    = cnt_q;
        inc_v    = '0;
        dec_v    = '0;
        wb_err_d = wb_err_q | (wb_live && (cnt_q[wb_addr] == '0));
        if (wb_live) begin
            regs_d[wb_addr] = wb_data;
        end
        for (int i = 1; i < REGS; i++) begin
            inc_v[i] = issue_ok && (issue_rd == AW'(i));
            dec_v[i] = wb_live && (wb_addr == AW'(i)) &&
                       (cnt_q[i] != '0);
            unique case ({inc_v[i], dec_v[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: stimulus pushes expected outputs into a queue, a monitor
// on the falling edge pops and compares them against the DUT.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic [2:0]  rs1_addr = '0;
    logic [2:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_en = 1'b0;
    logic [2:0]  issue_rd = '0;
    logic        issue_ok;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    reg_file_scoreboard #(
        .WIDTH(32),
        .REGS (8),
        .CNT_W(2)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .issue_en(issue_en),
        .issue_rd(issue_rd),
        .issue_ok(issue_ok),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_err  (wb_err)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (rs1_data !== e.d1 || rs1_busy !== e.b1 ||
                rs2_data !== e.d2 || rs2_busy !== e.b2 ||
                issue_ok !== e.ok || wb_err !== e.err) begin
                errors++;
                $display("FAIL %s got d1=%h b1=%b d2=%h b2=%b ok=%b err=%b want d1=%h b1=%b d2=%h b2=%b ok=%b err=%b",
                         e.name, rs1_data, rs1_busy, rs2_data, rs2_busy,
                         issue_ok, wb_err, e.d1, e.b1, e.d2, e.b2,
                         e.ok, e.err);
            end
        end
    end

    task automatic cyc(
        input string       name,
        input logic        clr,
        input logic [2:0]  a1,
        input logic [2:0]  a2,
        input logic        ie,
        input logic [2:0]  ird,
        input logic        we,
        input logic [2:0]  wa,
        input logic [31:0] wd,
        input logic [31:0] e_d1,
        input logic        e_b1,
        input logic [31:0] e_d2,
        input logic        e_b2,
        input logic        e_ok,
        input logic        e_err
    );
        exp_t e;
        @(posedge clk);
        #1;
        clear_n  = clr;
        rs1_addr = a1;
        rs2_addr = a2;
        issue_en = ie;
        issue_rd = ird;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        e.name = name;
        e.d1   = e_d1;
        e.b1   = e_b1;
        e.d2   = e_d2;
        e.b2   = e_b2;
        e.ok   = e_ok;
        e.err  = e_err;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset held: issue_ok follows issue_en, no state change
        cyc("rst_state", 0, 3, 3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            cyc("rd_zero", 1, 3'(i), 3'(7 - i), 0, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0);
        end
        cyc("r3_bypass", 1, 3, 0, 0, 0, 1, 3, 32'h1234,
            32'h1234, 0, 0, 0, 0, 0);
        cyc("r3_held",   1, 3, 0, 0, 0, 0, 0, 0,
            32'h1234, 0, 0, 0, 0, 1);
        cyc("r3_async_clr", 0, 3, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0);
        cyc("r3_after_clr", 1, 3, 0, 0, 0, 0, 0, 0,
            0, 0, 0, 0, 0, 0);

        cyc("r5_issue",  1, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("r5_busy",   1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("r5_wb_byp", 1, 5, 5, 0, 0, 1, 5, 32'hDEADBEEF,
            32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
        cyc("r5_held",   1, 5, 0, 0, 0, 0, 0, 0,
            32'hDEADBEEF, 0, 0, 0, 0, 0);

        cyc("r2_iss1",   1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("r2_iss2",   1, 2, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("r2_iss3",   1, 2, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("r2_full",   1, 2, 0, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("r2_full_wb", 1, 2, 0, 1, 2, 1, 2, 32'h22,
            32'h22, 1, 0, 0, 1, 0);
        cyc("r2_still3", 1, 2, 0, 1, 2, 0, 0, 0,
            32'h22, 1, 0, 0, 0, 0);

        cyc("r4_iss",    1, 0, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("r4_iss_wb", 1, 0, 4, 1, 4, 1, 4, 32'h44,
            0, 0, 32'h44, 0, 1, 0);
        cyc("r4_cnt1",   1, 0, 4, 0, 0, 0, 0, 0,
            0, 0, 32'h44, 1, 0, 0);

        cyc("r6_wb_cnt0", 1, 6, 0, 0, 0, 1, 6, 32'h66,
            32'h66, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc("err_sticky", 1, 6, 0, 0, 0, 0, 0, 0,
                32'h66, 0, 0, 0, 0, 1);
        end
        cyc("r0_wb",     1, 0, 0, 0, 0, 1, 0, 32'hFFFF,
            0, 0, 0, 0, 0, 1);
        cyc("r0_after",  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // reset drops every in-flight count, including R2 at MAX
        cyc("clr_cnts",  0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("post_clr",  1, 2, 4, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("post_iss",  1, 2, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        rs1_addr = '0;
        rs2_addr = '0;
        issue_en = 1'b0;
        wb_en    = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0",
                     exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
